// File: rtl/gray_ext_pkg.sv
// Shared types, default widths and the gray-to-binary helper for the gray extension scheduler.
package gray_ext_pkg;

    localparam int unsigned DEFAULT_GRAY_W = 6;
    localparam int unsigned DEFAULT_EXT_W  = 6;
    localparam int unsigned GRAY_MAX_W     = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t EMIT = 2'd2;

    function automatic int unsigned out_w(input int unsigned gray_w, input int unsigned ext_w);
        return gray_w + ext_w;
    endfunction

    // Zero-extended inputs convert correctly: leading zero gray bits leave lower binary bits as-is.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ext_chan_state.sv
// Per-channel history register file: MSB history, extension count, last result and primed flag.
module gray_ext_chan_state
    import gray_ext_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned EXT_W  = DEFAULT_EXT_W,
    parameter int unsigned OUT_W  = out_w(DEFAULT_GRAY_W, DEFAULT_EXT_W),
    localparam int unsigned PTR_W = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic             wr_msb,
    input  logic [EXT_W-1:0] wr_ext,
    input  logic [OUT_W-1:0] wr_bin,
    input  logic [PTR_W-1:0] rd_idx,
    output logic             rd_msb,
    output logic [EXT_W-1:0] rd_ext,
    output logic [OUT_W-1:0] rd_bin,
    output logic             rd_primed
);

    logic             prev_msb_q [NUM_CH];
    logic [EXT_W-1:0] ext_q      [NUM_CH];
    logic [OUT_W-1:0] last_bin_q [NUM_CH];
    logic             primed_q   [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                prev_msb_q[k] <= 1'b0;
                ext_q[k]      <= '0;
                last_bin_q[k] <= '0;
                primed_q[k]   <= 1'b0;
            end
        end else if (wr_en) begin
            prev_msb_q[wr_idx] <= wr_msb;
            ext_q[wr_idx]      <= wr_ext;
            last_bin_q[wr_idx] <= wr_bin;
            primed_q[wr_idx]   <= 1'b1;
        end
    end

    assign rd_msb    = prev_msb_q[rd_idx];
    assign rd_ext    = ext_q[rd_idx];
    assign rd_bin    = last_bin_q[rd_idx];
    assign rd_primed = primed_q[rd_idx];

endmodule

// File: rtl/gray_ext_scheduler.sv
// Time-shares one gray-to-binary/extension datapath across NUM_CH sampled gray counters and
// emits one {extension, binary} result plus delta per enabled channel over a valid/ready port.
module gray_ext_scheduler
    import gray_ext_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned GRAY_W = DEFAULT_GRAY_W,
    parameter int unsigned EXT_W  = DEFAULT_EXT_W,
    localparam int unsigned OUT_W = out_w(GRAY_W, EXT_W),
    localparam int unsigned PTR_W = $clog2(NUM_CH)
) (
    input  logic                     CLK_24M,
    input  logic                     reset,
    input  logic                     sample_strobe,
    input  logic [NUM_CH*GRAY_W-1:0] gray_in,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PTR_W-1:0]         out_ch,
    output logic [OUT_W-1:0]         out_bin,
    output logic [OUT_W-1:0]         out_delta,
    output logic                     out_first,
    output logic                     busy,
    output logic                     overrun
);

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [NUM_CH*GRAY_W-1:0]  cap_gray_q, cap_gray_d;
    logic [NUM_CH-1:0]         cap_en_q, cap_en_d;
    logic                      out_valid_q, out_valid_d;
    logic [PTR_W-1:0]          out_ch_q, out_ch_d;
    logic [OUT_W-1:0]          out_bin_q, out_bin_d;
    logic [OUT_W-1:0]          out_delta_q, out_delta_d;
    logic                      out_first_q, out_first_d;
    logic                      overrun_q, overrun_d;

    logic [GRAY_W-1:0]         cur_gray;
    logic [GRAY_W-1:0]         bin_lo;
    logic [EXT_W-1:0]          ext_n;
    logic [OUT_W-1:0]          bin_n;
    logic                      last_ch;
    logic                      commit;

    logic                      rd_msb;
    logic [EXT_W-1:0]          rd_ext;
    logic [OUT_W-1:0]          rd_bin;
    logic                      rd_primed;

    assign cur_gray = cap_gray_q[ptr_q*GRAY_W +: GRAY_W];
    assign bin_lo   = GRAY_W'(gray2bin(GRAY_MAX_W'(cur_gray)));
    // A falling MSB (1 -> 0) since the last committed sample means the counter wrapped.
    assign ext_n    = (rd_msb && !cur_gray[GRAY_W-1]) ? rd_ext + EXT_W'(1) : rd_ext;
    assign bin_n    = {ext_n, bin_lo};
    assign last_ch  = (ptr_q == PTR_W'(NUM_CH - 1));

    gray_ext_chan_state #(
        .NUM_CH (NUM_CH),
        .EXT_W  (EXT_W),
        .OUT_W  (OUT_W)
    ) u_chan_state (
        .clk       (CLK_24M),
        .reset     (reset),
        .wr_en     (commit),
        .wr_idx    (ptr_q),
        .wr_msb    (cur_gray[GRAY_W-1]),
        .wr_ext    (out_bin_q[OUT_W-1:GRAY_W]),
        .wr_bin    (out_bin_q),
        .rd_idx    (ptr_q),
        .rd_msb    (rd_msb),
        .rd_ext    (rd_ext),
        .rd_bin    (rd_bin),
        .rd_primed (rd_primed)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cap_gray_d  = cap_gray_q;
        cap_en_d    = cap_en_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_bin_d   = out_bin_q;
        out_delta_d = out_delta_q;
        out_first_d = out_first_q;
        commit      = 1'b0;
        overrun_d   = sample_strobe && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    cap_gray_d = gray_in;
                    cap_en_d   = ch_enable;
                    ptr_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (cap_en_q[ptr_q]) begin
                    out_valid_d = 1'b1;
                    out_ch_d    = ptr_q;
                    out_bin_d   = bin_n;
                    out_delta_d = rd_primed ? bin_n - rd_bin : '0;
                    out_first_d = ~rd_primed;
                    state_d     = EMIT;
                end else if (last_ch) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    commit      = 1'b1;
                    out_valid_d = 1'b0;
                    if (last_ch) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cap_gray_q  <= '0;
            cap_en_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_bin_q   <= '0;
            out_delta_q <= '0;
            out_first_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cap_gray_q  <= cap_gray_d;
            cap_en_q    <= cap_en_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_bin_q   <= out_bin_d;
            out_delta_q <= out_delta_d;
            out_first_q <= out_first_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_bin   = out_bin_q;
    assign out_delta = out_delta_q;
    assign out_first = out_first_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_ext_scheduler.sv
// Directed bench for gray_ext_scheduler with a per-strobe result model and a per-cycle comparator.
module tb_gray_ext_scheduler;

    localparam int NUM_CH = 4;
    localparam int GRAY_W = 6;
    localparam int EXT_W  = 6;
    localparam int OUT_W  = 12;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     sample_strobe = 1'b0;
    logic [NUM_CH*GRAY_W-1:0] gray_in = '0;
    logic [NUM_CH-1:0]        ch_enable = '0;
    logic                     out_ready = 1'b1;
    logic                     out_valid;
    logic [1:0]               out_ch;
    logic [OUT_W-1:0]         out_bin;
    logic [OUT_W-1:0]         out_delta;
    logic                     out_first;
    logic                     busy;
    logic                     overrun;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    gray_ext_scheduler #(
        .NUM_CH (NUM_CH),
        .GRAY_W (GRAY_W),
        .EXT_W  (EXT_W)
    ) dut (
        .CLK_24M       (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .gray_in       (gray_in),
        .ch_enable     (ch_enable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ch        (out_ch),
        .out_bin       (out_bin),
        .out_delta     (out_delta),
        .out_first     (out_first),
        .busy          (busy),
        .overrun       (overrun)
    );

    typedef struct {
        int               ch;
        logic [OUT_W-1:0] bin;
        logic [OUT_W-1:0] delta;
        logic             first;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             cmp_e;
    logic             m_msb    [NUM_CH];
    int               m_ext    [NUM_CH];
    logic [OUT_W-1:0] m_last   [NUM_CH];
    logic             m_primed [NUM_CH];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Binary bit i is the parity of all gray bits at or above i.
    function automatic logic [GRAY_W-1:0] to_bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        logic [GRAY_W-1:0] t;
        for (int i = 0; i < GRAY_W; i++) begin
            t    = g >> i;
            b[i] = ^t;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_msb[k]    = 1'b0;
            m_ext[k]    = 0;
            m_last[k]   = '0;
            m_primed[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Every result of a scan is assumed to be accepted, so history updates at strobe time.
    task automatic model_sample(input logic [NUM_CH*GRAY_W-1:0] g_all, input logic [NUM_CH-1:0] en);
        exp_t             e;
        logic [GRAY_W-1:0] g;
        logic [EXT_W-1:0]  x;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en[k]) begin
                g = g_all[k*GRAY_W +: GRAY_W];
                if (m_msb[k] && !g[GRAY_W-1]) m_ext[k] = (m_ext[k] + 1) % 64;
                x       = EXT_W'(m_ext[k]);
                e.ch    = k;
                e.bin   = {x, to_bin(g)};
                e.delta = m_primed[k] ? e.bin - m_last[k] : '0;
                e.first = !m_primed[k];
                exp_q.push_back(e);
                m_msb[k]    = g[GRAY_W-1];
                m_last[k]   = e.bin;
                m_primed[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stray_result ch=%0d bin=%0h", out_ch, out_bin);
            end else begin
                cmp_e = exp_q[0];
                if (out_ch !== 2'(cmp_e.ch) || out_bin !== cmp_e.bin ||
                    out_delta !== cmp_e.delta || out_first !== cmp_e.first) begin
                    errors++;
                    $display("FAIL result got ch=%0d bin=%0h delta=%0h first=%0b want ch=%0d bin=%0h delta=%0h first=%0b",
                             out_ch, out_bin, out_delta, out_first,
                             cmp_e.ch, cmp_e.bin, cmp_e.delta, cmp_e.first);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_strobe(input logic [NUM_CH*GRAY_W-1:0] g, input logic [NUM_CH-1:0] en);
        @(posedge clk);
        #1;
        gray_in       = g;
        ch_enable     = en;
        sample_strobe = 1'b1;
        model_sample(g, en);
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
    endtask

    // Runs the current scan to completion, optionally stalling one channel's result.
    task automatic drain(input int stall_ch, input int stall_n);
        int left  = stall_n;
        int phase = 0;
        bit done  = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk);
            #1;
            check("no_overrun", overrun, 0);
            if (phase == 1) begin
                check("bp_gap_valid", out_valid, 0);
                phase = 2;
            end else if (phase == 2) begin
                check("bp_next_valid", out_valid, 1);
                check("bp_next_ch", out_ch, stall_ch + 1);
                phase = 3;
            end
            if (out_valid && out_ch == stall_ch && left > 0) begin
                out_ready = 1'b0;
                left--;
            end else begin
                out_ready = 1'b1;
            end
            if (stall_ch >= 0 && phase == 0 && out_valid && out_ready && out_ch == stall_ch) phase = 1;
            if (!busy && !out_valid) done = 1'b1;
        end
        out_ready = 1'b1;
        check("drain_done", done, 1);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_bin", out_bin, 0);
        check("rst_delta", out_delta, 0);
        check("rst_first", out_first, 0);
        check("rst_ch", out_ch, 0);

        // Single channel, latency t+2.
        do_strobe(24'b000000_000000_000000_000011, 4'b0001);
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("first_bin", out_bin, 12'h002);
        check("first_first", out_first, 1);
        check("first_delta", out_delta, 0);
        drain(-1, 0);
        check("idle_busy", busy, 0);

        // Counter wrap through the MSB history.
        do_strobe(24'b000000_000000_000000_100000, 4'b0001);
        drain(-1, 0);
        do_strobe(24'b000000_000000_000000_000011, 4'b0001);
        @(posedge clk);
        #1;
        check("wrap_bin", out_bin, 12'h042);
        check("wrap_delta", out_delta, 12'h003);
        check("wrap_first", out_first, 0);
        drain(-1, 0);

        // Backpressure on channel 1.
        do_strobe(24'b101010_011110_110101_000011, 4'b1111);
        drain(1, 5);

        // Strobe while busy is dropped; changed inputs must not leak into the scan.
        do_strobe(24'b111000_000110_100001_100100, 4'b1111);
        @(posedge clk);
        #1;
        gray_in       = 24'hFFFFFF;
        ch_enable     = 4'b0000;
        sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        check("overrun_pulse", overrun, 1);
        @(posedge clk);
        #1;
        check("overrun_end", overrun, 0);
        drain(-1, 0);

        // Partial enable, then a full scan to expose any stray update on ch1/ch3.
        do_strobe(24'b000000_010111_000000_000101, 4'b0101);
        drain(-1, 0);
        do_strobe(24'b000001_010100_000001_000111, 4'b1111);
        drain(-1, 0);

        // Reset while a result is held.
        out_ready = 1'b0;
        do_strobe(24'b001100_010001_011011_101101, 4'b1111);
        @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        do_strobe(24'b001100_010001_011011_101101, 4'b1011);
        @(posedge clk);
        #1;
        check("post_rst_first", out_first, 1);
        check("post_rst_ch", out_ch, 0);
        drain(-1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
